fp16_normalizer: RTL and testbench

Converts one block-fixed-point accumulator result (signed integer sum plus the shared 5-bit exponent chosen by the exponent-alignment stage of the SD4 MAC) back into an IEEE-754 binary16 word. It sits at the output end of the MAC datapath, is the inverse of the max-exponent/alignment front end, and normalizes iteratively, one bit per cycle, behind valid/ready handshakes on both sides.

---
 rtl/fp16_normalizer.sv | 121 ++++++++++++
 tb/tb_fp16_normalizer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fp16_normalizer.sv
// fp16_normalizer: converts a block-fixed-point accumulator sum and shared exponent into binary16,
// normalizing one bit per cycle behind valid/ready handshakes.
module fp16_normalizer #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] sum,
    input  logic [4:0]       exp_shared,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_ovf,
    output logic             out_inexact
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              sign_q, sign_d;
    logic [ACC_W-1:0]  mag_q, mag_d;
    logic signed [7:0] e_q, e_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_ovf_q, out_ovf_d;
    logic              out_inexact_q, out_inexact_d;

    logic              rnd_inc, is_zero, ovf;
    logic [11:0]       m_r;
    logic [10:0]       m_f;
    logic signed [7:0] e_f;

    // Rounding operates on the 11-bit significand left by NORM; a carry out renormalizes.
    assign rnd_inc = guard_q & (sticky_q | mag_q[0]);
    assign m_r     = {1'b0, mag_q[10:0]} + {11'd0, rnd_inc};
    assign m_f     = m_r[11] ? 11'h400 : m_r[10:0];
    assign e_f     = e_q + (m_r[11] ? 8'sd1 : 8'sd0);
    assign ovf     = e_f >= 8'sd31;
    assign is_zero = mag_q == '0;

    always_comb begin
        state_d       = state_q;
        sign_d        = sign_q;
        mag_d         = mag_q;
        e_d           = e_q;
        guard_d       = guard_q;
        sticky_d      = sticky_q;
        out_data_d    = out_data_q;
        out_ovf_d     = out_ovf_q;
        out_inexact_d = out_inexact_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d   = sum[ACC_W-1];
                mag_d    = sum[ACC_W-1] ? -sum : sum;
                e_d      = {3'd0, exp_shared};
                guard_d  = 1'b0;
                sticky_d = 1'b0;
                state_d  = NORM;
            end
            NORM: if (is_zero) begin
                state_d = ROUND;
            end else if (mag_q >= ACC_W'(2048) || e_q < 8'sd1) begin
                sticky_d = sticky_q | guard_q;
                guard_d  = mag_q[0];
                mag_d    = mag_q >> 1;
                e_d      = e_q + 8'sd1;
            end else if (mag_q < ACC_W'(1024) && e_q > 8'sd1) begin
                mag_d = mag_q << 1;
                e_d   = e_q - 8'sd1;
            end else begin
                state_d = ROUND;
            end
            ROUND: begin
                mag_d         = ACC_W'(m_f);
                e_d           = e_f;
                out_data_d    = is_zero ? 16'h0000 :
                                ovf     ? {sign_q, 5'h1F, 10'h000} :
                                          {sign_q, m_f[10] ? e_f[4:0] : 5'd0, m_f[9:0]};
                out_ovf_d     = !is_zero & ovf;
                out_inexact_d = !is_zero & (ovf | guard_q | sticky_q);
                state_d       = DONE;
            end
            default: if (out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sign_q        <= 1'b0;
            mag_q         <= '0;
            e_q           <= '0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            out_data_q    <= '0;
            out_ovf_q     <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sign_q        <= sign_d;
            mag_q         <= mag_d;
            e_q           <= e_d;
            guard_q       <= guard_d;
            sticky_q      <= sticky_d;
            out_data_q    <= out_data_d;
            out_ovf_q     <= out_ovf_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign in_ready    = rst_n && state_q == IDLE;
    assign out_valid   = state_q == DONE;
    assign out_data    = out_data_q;
    assign out_ovf     = out_ovf_q;
    assign out_inexact = out_inexact_q;
endmodule

// File: tb/tb_fp16_normalizer.sv
// tb_fp16_normalizer: directed vectors with a scoreboard queue and an independent output monitor.
module tb_fp16_normalizer;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] sum = '0;
    logic [4:0]       exp_shared = '0;
    logic             in_ready, out_valid, out_ovf, out_inexact;
    logic [15:0]      out_data;

    fp16_normalizer #(.ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .exp_shared(exp_shared), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf), .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        ovf;
        logic        inx;
        int          lat;
        int          start;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !ov_prev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got out_valid with data %0h, expected none", out_data);
            end else begin
                chk({sb[0].name, " latency"}, cyc - sb[0].start, sb[0].lat);
            end
        end
        if (out_valid && out_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, " data"}, {16'd0, out_data}, {16'd0, e.d});
            chk({e.name, " ovf"}, {31'd0, out_ovf}, {31'd0, e.ovf});
            chk({e.name, " inexact"}, {31'd0, out_inexact}, {31'd0, e.inx});
        end
        ov_prev = out_valid;
    end

    task automatic send(input logic [ACC_W-1:0] s, input logic [4:0] e, input logic [15:0] d,
                        input logic ovf, input logic inx, input int lat, input string nm, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL %s accept_timeout: in_ready got 0 expected 1", nm);
        end
        sum        = s;
        exp_shared = e;
        in_valid   = 1'b1;
        if (push) sb.push_back('{d: d, ovf: ovf, inx: inx, lat: lat, start: cyc + 1, name: nm});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout: pending %0d expected 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [ACC_W-1:0] s, input logic [4:0] e, input logic [15:0] d,
                       input logic ovf, input logic inx, input int lat, input string nm);
        send(s, e, d, ovf, inx, lat, nm, 1'b1);
        wait_done(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst out_valid", {31'd0, out_valid}, 0);
        chk("rst in_ready", {31'd0, in_ready}, 0);
        chk("rst out_data", {16'd0, out_data}, 0);
        chk("rst flags", {30'd0, out_ovf, out_inexact}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel in_ready", {31'd0, in_ready}, 1);

        run(24'd1024,          5'd15, 16'h3C00, 0, 0, 2,  "one");
        run(24'd0,             5'd7,  16'h0000, 0, 0, 2,  "zero");
        run(24'd0,             5'd31, 16'h0000, 0, 0, 2,  "zero_e31");
        run(ACC_W'(-3072),     5'd15, 16'hC200, 0, 0, 3,  "neg3072");
        run(24'd1,             5'd25, 16'h3C00, 0, 0, 12, "left10");
        run(24'd2049,          5'd15, 16'h4000, 0, 1, 3,  "tie_even");
        run(24'd2051,          5'd15, 16'h4002, 0, 1, 3,  "round_up");
        run(24'd512,           5'd1,  16'h0200, 0, 0, 2,  "subnormal");
        run(24'h7FFFFF,        5'd30, 16'h7C00, 1, 1, 14, "ovf_pos");
        run(24'h800000,        5'd30, 16'hFC00, 1, 1, 15, "ovf_neg");
        run(24'd2047,          5'd0,  16'h0400, 0, 1, 3,  "e0_round");
        run(24'd1,             5'd2,  16'h0002, 0, 0, 3,  "sub_left");
        run(ACC_W'(-1),        5'd0,  16'h0000, 0, 0, 3,  "neg_to_zero");

        out_ready = 1'b0;
        send(24'd1024, 5'd15, 16'h3C00, 0, 0, 2, "bp", 1'b1);
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        chk("bp out_valid", {31'd0, out_valid}, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = (i == 1);
            sum        = 24'd5;
            exp_shared = 5'd3;
            chk("bp hold data", {16'd0, out_data}, 32'h3C00);
            chk("bp hold in_ready", {31'd0, in_ready}, 0);
            chk("bp hold valid", {31'd0, out_valid}, 1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done("bp");
        repeat (20) @(negedge clk);

        send(24'd1, 5'd25, 16'h3C00, 0, 0, 12, "aborted", 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort out_valid", {31'd0, out_valid}, 0);
        chk("abort in_ready", {31'd0, in_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort rel in_ready", {31'd0, in_ready}, 1);
        chk("abort rel out_valid", {31'd0, out_valid}, 0);
        repeat (15) @(negedge clk);
        run(24'd1024, 5'd15, 16'h3C00, 0, 0, 2, "after_abort");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
